fetch_queue: RTL

Instruction prefetch queue between the fetch stage and the decode stage of the pipelined RISC-V core. It buffers up to DEPTH fetched instruction/PC+1 pairs so fetch keeps running while decode is stalled by the hazard unit. On a taken branch or jump from the memory stage it discards every buffered entry. When empty it presents a NOP bubble to decode.

---
 rtl/fetch_queue.sv | 78 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction/PC+1 prefetch queue between fetch and decode
// Circular buffer with flush-on-redirect and a NOP bubble when empty.
module fetch_queue #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter logic [INSTR_W-1:0] NOP = 'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       instr_i,
  input  logic [PC_W-1:0]          pc_plus1_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [INSTR_W-1:0]       instr_o,
  output logic [PC_W-1:0]          pc_plus1_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;
  logic clear;

  // Status depends only on registered occupancy, so a full queue refuses a
  // push even in a cycle where decode pops.
  assign ready_o = (count != CNT_W'(DEPTH));
  assign valid_o = (count != '0);
  assign count_o = count;

  assign push  = valid_i & ready_o;
  assign pop   = valid_o & ready_i;
  assign clear = reset | flush_i;

  assign instr_o    = valid_o ? instr_mem[rptr] : NOP;
  assign pc_plus1_o = valid_o ? pc_mem[rptr]    : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      instr_mem[wptr] <= instr_i;
      pc_mem[wptr]    <= pc_plus1_i;
    end
  end

endmodule
